// File: rtl/majority_voter_tmr_if.sv
// Bundle of the three redundant copies, the sampling controls and all
// voter results, shared between the voter and whatever drives it.
interface majority_voter_tmr_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] OUT;
  logic             err_a;
  logic             err_b;
  logic             err_c;
  logic             multi_fault;
  logic             sticky_fault;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;

  // The driver of the redundant copies and controls
  modport master (
    output A, B, C, en, clr,
    input  OUT, err_a, err_b, err_c, multi_fault, sticky_fault,
    input  cnt_a, cnt_b, cnt_c
  );

  // The voter itself
  modport slave (
    input  A, B, C, en, clr,
    output OUT, err_a, err_b, err_c, multi_fault, sticky_fault,
    output cnt_a, cnt_b, cnt_c
  );
endinterface

// File: rtl/majority_voter_tmr.sv
// Bitwise 2-of-3 voter with per-copy fault flags, a multi-copy fault flag,
// a sticky fault flag and saturating per-copy fault counters.
// The voted word is combinational; all bookkeeping is registered.
module majority_voter_tmr #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  majority_voter_tmr_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] voted;
  logic             da;
  logic             db;
  logic             dc;
  logic             multi_now;

  logic             err_a_q;
  logic             err_b_q;
  logic             err_c_q;
  logic             multi_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;
  logic [CNT_W-1:0] cnt_c_q;

  // Majority per bit, and which copies disagree with it anywhere in the word
  always_comb begin
    voted     = (bus.A & bus.B) | (bus.A & bus.C) | (bus.B & bus.C);
    da        = |(bus.A ^ voted);
    db        = |(bus.B ^ voted);
    dc        = |(bus.C ^ voted);
    multi_now = (da & db) | (da & dc) | (db & dc);
  end

  // Fault flags: clear wins over sampling, and disabled cycles hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
      err_c_q  <= 1'b0;
      multi_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else if (bus.clr) begin
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
      err_c_q  <= 1'b0;
      multi_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else if (bus.en) begin
      err_a_q  <= da;
      err_b_q  <= db;
      err_c_q  <= dc;
      multi_q  <= multi_now;
      sticky_q <= sticky_q | da | db | dc;
    end
  end

  // Per-copy fault counters that stop at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else if (bus.clr) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else if (bus.en) begin
      if (da && (cnt_a_q != CNT_MAX)) cnt_a_q <= cnt_a_q + 1'b1;
      if (db && (cnt_b_q != CNT_MAX)) cnt_b_q <= cnt_b_q + 1'b1;
      if (dc && (cnt_c_q != CNT_MAX)) cnt_c_q <= cnt_c_q + 1'b1;
    end
  end

  assign bus.OUT          = voted;
  assign bus.err_a        = err_a_q;
  assign bus.err_b        = err_b_q;
  assign bus.err_c        = err_c_q;
  assign bus.multi_fault  = multi_q;
  assign bus.sticky_fault = sticky_q;
  assign bus.cnt_a        = cnt_a_q;
  assign bus.cnt_b        = cnt_b_q;
  assign bus.cnt_c        = cnt_c_q;

endmodule

// File: tb/tb_majority_voter_tmr.sv
// Self-checking bench for majority_voter_tmr (WIDTH=4, CNT_W=2): directed
// scenarios with literal expectations plus a randomized run compared every
// cycle against a vote-counting reference model.
module tb_majority_voter_tmr;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  bit   check_on;
  int   checks;
  int   passes;

  majority_voter_tmr_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  majority_voter_tmr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count votes per bit: a bit is 1 when at least two copies say 1
  function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    int votes;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      votes = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i]  = (votes >= 2);
    end
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  logic [WIDTH-1:0] ref_out;
  logic             ref_da;
  logic             ref_db;
  logic             ref_dc;

  // Reference vote and per-copy disagreement for the current inputs
  always_comb begin
    ref_out = vote(bus.A, bus.B, bus.C);
    ref_da  = (bus.A != ref_out);
    ref_db  = (bus.B != ref_out);
    ref_dc  = (bus.C != ref_out);
  end

  bit m_err_a, m_err_b, m_err_c, m_multi, m_sticky;
  int m_cnt_a, m_cnt_b, m_cnt_c;

  // Reference status bookkeeping
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err_a <= 0; m_err_b <= 0; m_err_c <= 0;
      m_multi <= 0; m_sticky <= 0;
      m_cnt_a <= 0; m_cnt_b <= 0; m_cnt_c <= 0;
    end else if (bus.clr) begin
      m_err_a <= 0; m_err_b <= 0; m_err_c <= 0;
      m_multi <= 0; m_sticky <= 0;
      m_cnt_a <= 0; m_cnt_b <= 0; m_cnt_c <= 0;
    end else if (bus.en) begin
      m_err_a  <= ref_da;
      m_err_b  <= ref_db;
      m_err_c  <= ref_dc;
      m_multi  <= (int'(ref_da) + int'(ref_db) + int'(ref_dc)) >= 2;
      m_sticky <= m_sticky | ref_da | ref_db | ref_dc;
      if (ref_da) m_cnt_a <= sat_inc(m_cnt_a);
      if (ref_db) m_cnt_b <= sat_inc(m_cnt_b);
      if (ref_dc) m_cnt_c <= sat_inc(m_cnt_c);
    end
  end

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic check_output();
    check_val("model_out",    int'(bus.OUT),          int'(ref_out));
    check_val("model_err_a",  int'(bus.err_a),        int'(m_err_a));
    check_val("model_err_b",  int'(bus.err_b),        int'(m_err_b));
    check_val("model_err_c",  int'(bus.err_c),        int'(m_err_c));
    check_val("model_multi",  int'(bus.multi_fault),  int'(m_multi));
    check_val("model_sticky", int'(bus.sticky_fault), int'(m_sticky));
    check_val("model_cnt_a",  int'(bus.cnt_a),        m_cnt_a);
    check_val("model_cnt_b",  int'(bus.cnt_b),        m_cnt_b);
    check_val("model_cnt_c",  int'(bus.cnt_c),        m_cnt_c);
  endtask

  // Every cycle, midway between rising edges, compare DUT against the model
  always @(negedge clk) begin
    if (check_on) check_output();
  end

  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] c, input logic e, input logic cl);
    bus.A   = a;
    bus.B   = b;
    bus.C   = c;
    bus.en  = e;
    bus.clr = cl;
  endtask

  // Advance to 2 time units past the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_status_zero(input string tag);
    check_val({tag, "_err_a"},  int'(bus.err_a), 0);
    check_val({tag, "_err_b"},  int'(bus.err_b), 0);
    check_val({tag, "_err_c"},  int'(bus.err_c), 0);
    check_val({tag, "_multi"},  int'(bus.multi_fault), 0);
    check_val({tag, "_sticky"}, int'(bus.sticky_fault), 0);
    check_val({tag, "_cnt_a"},  int'(bus.cnt_a), 0);
    check_val({tag, "_cnt_b"},  int'(bus.cnt_b), 0);
    check_val({tag, "_cnt_c"},  int'(bus.cnt_c), 0);
  endtask

  logic [2:0] sweep_abc [8];
  int         sweep_out [8];
  int         sat_seq   [5];

  initial begin
    logic [WIDTH-1:0] base, ra, rb, rc;
    logic [2:0] abc;
    sweep_abc = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    sweep_out = '{0, 0, 0, 1, 0, 1, 1, 1};
    sat_seq   = '{1, 2, 3, 3, 3};
    checks   = 0;
    passes   = 0;
    check_on = 0;
    rst_n    = 1'b1;
    apply_stimulus('0, '0, '0, 1'b0, 1'b0);

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2 check_status_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check_on = 1;

    // Single-bit vote sweep with sampling disabled
    for (int i = 0; i < 8; i++) begin
      abc = sweep_abc[i];
      apply_stimulus({3'b000, abc[2]}, {3'b000, abc[1]}, {3'b000, abc[0]}, 1'b0, 1'b0);
      #50 check_val($sformatf("sweep_out_%0d", i), int'(bus.OUT), sweep_out[i]);
      #50;
    end

    // Copy A alone disagrees for one sampled edge
    apply_stimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0);
    #1 check_val("single_out", int'(bus.OUT), 0);
    step();
    check_val("single_err_a",  int'(bus.err_a), 1);
    check_val("single_err_b",  int'(bus.err_b), 0);
    check_val("single_err_c",  int'(bus.err_c), 0);
    check_val("single_cnt_a",  int'(bus.cnt_a), 1);
    check_val("single_sticky", int'(bus.sticky_fault), 1);
    check_val("single_multi",  int'(bus.multi_fault), 0);

    // A and B wrong in different bits of the same word
    apply_stimulus(4'b0001, 4'b0010, 4'b0000, 1'b1, 1'b0);
    #1 check_val("multi_out", int'(bus.OUT), 0);
    step();
    check_val("multi_err_a", int'(bus.err_a), 1);
    check_val("multi_err_b", int'(bus.err_b), 1);
    check_val("multi_err_c", int'(bus.err_c), 0);
    check_val("multi_flag",  int'(bus.multi_fault), 1);
    check_val("multi_cnt_a", int'(bus.cnt_a), 2);

    // C held faulty: counter saturates at 3, then clr wipes it
    apply_stimulus(4'b0101, 4'b0101, 4'b1010, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("sat_cnt_c_%0d", i), int'(bus.cnt_c), sat_seq[i]);
    end
    check_val("sat_err_c", int'(bus.err_c), 1);
    apply_stimulus(4'b0101, 4'b0101, 4'b1010, 1'b1, 1'b1);
    step();
    check_status_zero("clr");

    // Disabled sampling holds status while OUT keeps voting
    apply_stimulus(4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step();
    apply_stimulus(4'b0000, 4'b0110, 4'b0000, 1'b0, 1'b0);
    repeat (3) step();
    apply_stimulus(4'b0011, 4'b0011, 4'b1100, 1'b0, 1'b0);
    #1 check_val("hold_out", int'(bus.OUT), 3);
    step();
    check_val("hold_err_a",  int'(bus.err_a), 1);
    check_val("hold_err_c",  int'(bus.err_c), 0);
    check_val("hold_cnt_a",  int'(bus.cnt_a), 1);
    check_val("hold_cnt_c",  int'(bus.cnt_c), 0);
    check_val("hold_sticky", int'(bus.sticky_fault), 1);

    // clr beats en: faulty inputs leave status at zero
    apply_stimulus(4'b0011, 4'b0111, 4'b1100, 1'b1, 1'b1);
    repeat (3) step();
    check_status_zero("clr_en");

    // Randomized traffic checked by the model on every cycle
    for (int n = 0; n < 1500; n++) begin
      base = WIDTH'($urandom_range(0, 15));
      ra = base; rb = base; rc = base;
      if ($urandom_range(0, 2) == 0) ra = ra ^ WIDTH'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) rb = rb ^ WIDTH'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) rc = rc ^ WIDTH'($urandom_range(1, 15));
      apply_stimulus(ra, rb, rc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      step();
    end

    // Mid-run asynchronous reset with nonzero counters
    apply_stimulus(4'b0101, 4'b0101, 4'b1010, 1'b1, 1'b1);
    step();
    apply_stimulus(4'b0101, 4'b0101, 4'b1010, 1'b1, 1'b0);
    repeat (2) step();
    check_val("pre_reset_cnt_c", int'(bus.cnt_c), 2);
    #1 rst_n = 1'b0;
    #1 check_status_zero("midreset");
    check_val("midreset_out", int'(bus.OUT), 5);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/majority_voter_tmr.md
# majority_voter_tmr

Bitwise triple-modular-redundancy (TMR) voter with fault bookkeeping. It takes three redundant copies of a WIDTH-bit word and produces the 2-of-3 majority combinationally on OUT. Clocked logic flags which copy disagreed, detects multi-copy faults, and keeps saturating per-copy fault counters. It sits at the output of replicated logic, ahead of downstream consumers and a status/diagnostic block.

## Interface
Parameters:
- WIDTH, 1, width of each voted word.
- CNT_W, 8, width of each per-copy fault counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  redundant copy A.
- B  input  WIDTH  redundant copy B.
- C  input  WIDTH  redundant copy C.
- en  input  1  status-sampling enable.
- clr  input  1  synchronous clear of counters and sticky flags.
- OUT  output  WIDTH  bitwise majority, combinational.
- err_a  output  1  registered: A differed from OUT in at least one bit last sampled cycle.
- err_b  output  1  same for B.
- err_c  output  1  same for C.
- multi_fault  output  1  registered: two or more of err_a/b/c were set in the same sampled cycle.
- sticky_fault  output  1  set on any sampled error; held until clr or reset.
- cnt_a  output  CNT_W  saturating count of sampled cycles with A in error.
- cnt_b  output  CNT_W  same for B.
- cnt_c  output  CNT_W  same for C.

## Operation
- OUT[i] = (A[i]&B[i]) | (A[i]&C[i]) | (B[i]&C[i]) for every bit. OUT is purely combinational and independent of clk, rst_n, en and clr.
- Combinational mismatch terms: da = |(A^OUT), db = |(B^OUT), dc = |(C^OUT).
- A single bit can disagree in at most one copy. Across a multi-bit word, different copies can each be wrong in different bits, so more than one of da/db/dc can be set.
- On a rising edge with en=1 and clr=0:
  - err_a/b/c <= da/db/dc.
  - multi_fault <= (da+db+dc) >= 2.
  - sticky_fault <= sticky_fault | da | db | dc.
  - Each cnt_x increments by 1 when its dx=1 and saturates at 2^CNT_W-1; it never wraps.
- On a rising edge with en=0 and clr=0: all registered outputs hold.
- On a rising edge with clr=1: counters, sticky_fault, err_* and multi_fault go to 0. clr has priority over en, and that cycle's mismatches are discarded.
- Reset (rst_n=0), asynchronous: err_a/b/c=0, multi_fault=0, sticky_fault=0, cnt_a/b/c=0. OUT keeps following its inputs during reset.

## Timing
- OUT: zero-cycle latency; it settles within the combinational delay of an input change.
- Status outputs: one-cycle latency. They reflect inputs sampled at edge N and are visible after edge N.
- Reset asserts immediately, asynchronously. Deassertion is assumed synchronized externally, and the first update occurs on the first rising edge with rst_n=1.
- Reset asserted mid-operation clears all state immediately; nothing is preserved.
- Counter at saturation with a new error: the value stays at max, and sticky_fault and err_x still update.

## Test plan
- WIDTH=1, sweep all 8 (A,B,C) combinations 000,010,001,011,100,101,110,111 at 100-time-unit steps -> OUT = 0,0,0,1,0,1,1,1 respectively, with no clock dependence.
- WIDTH=1, en=1, A=1,B=0,C=0 for one clock -> OUT=0, and after the edge err_a=1, err_b=0, err_c=0, cnt_a=1, sticky_fault=1, multi_fault=0.
- WIDTH=4, en=1, A=4'b0001, B=4'b0010, C=4'b0000 -> OUT=4'b0000, and after the edge err_a=1, err_b=1, err_c=0, multi_fault=1.
- CNT_W=2, hold C faulty for 5 enabled cycles -> cnt_c sequence 1,2,3,3,3 (saturates, no wrap). Then assert clr for one edge -> cnt_c=0 and sticky_fault=0.
- Faulty inputs with en=0 for several edges -> all status outputs unchanged while OUT still tracks the majority. Same inputs with clr=1 and en=1 -> status stays 0.
- Assert rst_n=0 between clock edges with nonzero counters -> all status outputs 0 immediately, before the next edge; OUT unaffected.
